// File: rtl/lsu_pkg.sv
// lsu_pkg: shared definitions for the Wishbone load/store unit.
//   - RV32 funct3 encodings for loads and stores
//   - FSM state enum and access-size enum
//   - access_size(): request width from direction + funct3 (unknown -> word)
//   - sext_lane(): extract a byte/half lane from a word and zero/sign extend it
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'd0;
  localparam logic [2:0] F3_H  = 3'd1;
  localparam logic [2:0] F3_W  = 3'd2;
  localparam logic [2:0] F3_BU = 3'd4;
  localparam logic [2:0] F3_HU = 3'd5;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD      = 3'd1,
    RD_WAIT = 3'd2,
    WR      = 3'd3,
    WR_WAIT = 3'd4,
    RSP     = 3'd5
  } lsu_state_t;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2
  } acc_size_t;

  // BU/HU only exist for loads; a store carrying those codes is an unknown
  // encoding and therefore falls through to a full word.
  function automatic acc_size_t access_size(input logic we, input logic [2:0] funct3);
    acc_size_t sz;
    sz = SZ_W;
    if (funct3 == F3_B || (!we && funct3 == F3_BU)) begin
      sz = SZ_B;
    end else if (funct3 == F3_H || (!we && funct3 == F3_HU)) begin
      sz = SZ_H;
    end
    return sz;
  endfunction

  // Halfword lanes are selected by off[1] only; off[0] is assumed aligned.
  function automatic logic [31:0] sext_lane(input logic [31:0] word, input logic [1:0] off,
                                            input acc_size_t size, input logic sign);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    b = word[{off, 3'b000} +: 8];
    h = word[{off[1], 4'b0000} +: 16];
    case (size)
      SZ_B:    r = {{24{sign & b[7]}}, b};
      SZ_H:    r = {{16{sign & h[15]}}, h};
      default: r = word;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// lsu_align: combinational lane handling for the load/store unit.
// Ports:
//   funct3   in  3   funct3 of the latched request
//   lane     in  2   byte address bits [1:0] (already aligned for the size)
//   rd_word  in  32  word read from the bus
//   st_data  in  32  store data from the request (low bits used for SB/SH)
//   merged   out 32  read word with the store byte/half inserted (SW: st_data)
//   ld_value out 32  load result, zero or sign extended per funct3
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  lane,
  input  logic [31:0] rd_word,
  input  logic [31:0] st_data,
  output logic [31:0] merged,
  output logic [31:0] ld_value
);

  // Read-modify-write merge: only the addressed lane is replaced, the other
  // lanes keep the value just read from RAM.
  always_comb begin
    merged = rd_word;
    case (access_size(1'b1, funct3))
      SZ_B:    merged[{lane, 3'b000} +: 8]      = st_data[7:0];
      SZ_H:    merged[{lane[1], 4'b0000} +: 16] = st_data[15:0];
      default: merged = st_data;
    endcase
  end

  // funct3[2] distinguishes the unsigned load variants.
  assign ld_value = sext_lane(rd_word, lane, access_size(1'b0, funct3), ~funct3[2]);

endmodule

// File: rtl/wb_lsu.sv
// wb_lsu: RV32 load/store unit acting as a Wishbone master in front of a
// word-wide block RAM. One request at a time; one response pulse per request.
// Sub-word stores are done as read-modify-write since the RAM writes words.
//
// Optional feature macro: WB_LSU_MISALIGN_TRAP_EN
//   defined   - misaligned half/word accesses skip the bus and respond with
//               o_rsp_err=1 one cycle after acceptance.
//   undefined - low address bits are forced to alignment; o_rsp_err is 0.
//
// Ports:
//   i_clk, i_reset               clock, async active-high reset
//   i_req_valid / o_req_ready    request handshake (ready only in IDLE)
//   i_req_we, i_req_funct3       store flag, RV32 funct3
//   i_req_addr, i_req_wdata      byte address, store data
//   o_rsp_valid                  one-cycle response pulse
//   o_rsp_rdata, o_rsp_err       load result, misalignment error
//   o_wb_cyc/stb/we/addr/data/sel  Wishbone master outputs (sel = funct3)
//   i_wb_data/stall/ack          Wishbone slave returns
module wb_lsu
  import lsu_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int LGMEMSZ = 9
) (
  input  logic            i_clk,
  input  logic            i_reset,
  input  logic            i_req_valid,
  output logic            o_req_ready,
  input  logic            i_req_we,
  input  logic [2:0]      i_req_funct3,
  input  logic [XLEN-1:0] i_req_addr,
  input  logic [XLEN-1:0] i_req_wdata,
  output logic            o_rsp_valid,
  output logic [XLEN-1:0] o_rsp_rdata,
  output logic            o_rsp_err,
  output logic            o_wb_cyc,
  output logic            o_wb_stb,
  output logic            o_wb_we,
  output logic [XLEN-1:0] o_wb_addr,
  output logic [XLEN-1:0] o_wb_data,
  output logic [2:0]      o_wb_sel,
  input  logic [XLEN-1:0] i_wb_data,
  input  logic            i_wb_stall,
  input  logic            i_wb_ack
);

  lsu_state_t      state, next_state;
  logic            req_we;
  logic [2:0]      req_funct3;
  logic [XLEN-1:0] req_addr;
  logic [XLEN-1:0] bus_data;
  logic [XLEN-1:0] rsp_data;
  logic [XLEN-1:0] in_addr;
  acc_size_t       in_size;
  logic            accept;
  logic [31:0]     merged_word;
  logic [31:0]     load_value;
  logic            unused_addr_bits;
`ifdef WB_LSU_MISALIGN_TRAP_EN
  logic            misaligned;
  logic            rsp_err;
`endif

  assign accept  = (state == IDLE) && i_req_valid;
  assign in_size = access_size(i_req_we, i_req_funct3);

  // Address conditioning at acceptance: either flag a misaligned access or
  // silently clear the low bits the access size cannot use.
  always_comb begin
    in_addr = i_req_addr;
`ifdef WB_LSU_MISALIGN_TRAP_EN
    misaligned = 1'b0;
    case (in_size)
      SZ_H:    misaligned = i_req_addr[0];
      SZ_W:    misaligned = |i_req_addr[1:0];
      default: misaligned = 1'b0;
    endcase
`else
    case (in_size)
      SZ_H:    in_addr[0]   = 1'b0;
      SZ_W:    in_addr[1:0] = 2'b00;
      default: in_addr      = i_req_addr;
    endcase
`endif
  end

  // State register; reset abandons any bus cycle in flight.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state and bus/handshake outputs. Sub-word stores start with a read
  // so the untouched lanes can be written back unchanged.
  always_comb begin
    next_state  = state;
    o_req_ready = 1'b0;
    o_rsp_valid = 1'b0;
    o_wb_cyc    = 1'b0;
    o_wb_stb    = 1'b0;
    o_wb_we     = 1'b0;
    case (state)
      IDLE: begin
        o_req_ready = 1'b1;
        if (i_req_valid) begin
`ifdef WB_LSU_MISALIGN_TRAP_EN
          if (misaligned) begin
            next_state = RSP;
          end else
`endif
          if (!i_req_we || in_size != SZ_W) begin
            next_state = RD;
          end else begin
            next_state = WR;
          end
        end
      end
      RD: begin
        o_wb_cyc = 1'b1;
        o_wb_stb = 1'b1;
        if (!i_wb_stall) next_state = RD_WAIT;
      end
      RD_WAIT: begin
        o_wb_cyc = 1'b1;
        if (i_wb_ack) next_state = req_we ? WR : RSP;
      end
      WR: begin
        o_wb_cyc = 1'b1;
        o_wb_stb = 1'b1;
        o_wb_we  = 1'b1;
        if (!i_wb_stall) next_state = WR_WAIT;
      end
      WR_WAIT: begin
        o_wb_cyc = 1'b1;
        o_wb_we  = 1'b1;
        if (i_wb_ack) next_state = RSP;
      end
      RSP: begin
        o_rsp_valid = 1'b1;
        next_state  = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Request latch and read-data capture. bus_data first holds the raw store
  // data, then the merged word once the read of an SB/SH returns.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      req_we     <= 1'b0;
      req_funct3 <= '0;
      req_addr   <= '0;
      bus_data   <= '0;
      rsp_data   <= '0;
`ifdef WB_LSU_MISALIGN_TRAP_EN
      rsp_err    <= 1'b0;
`endif
    end else if (accept) begin
      req_we     <= i_req_we;
      req_funct3 <= i_req_funct3;
      req_addr   <= in_addr;
      bus_data   <= i_req_wdata;
      rsp_data   <= '0;
`ifdef WB_LSU_MISALIGN_TRAP_EN
      rsp_err    <= misaligned;
`endif
    end else if (state == RD_WAIT && i_wb_ack) begin
      if (req_we) begin
        bus_data <= merged_word;
      end else begin
        rsp_data <= load_value;
      end
    end
  end

  lsu_align u_align (
    .funct3   (req_funct3),
    .lane     (req_addr[1:0]),
    .rd_word  (i_wb_data),
    .st_data  (bus_data),
    .merged   (merged_word),
    .ld_value (load_value)
  );

  assign o_wb_addr   = {{(XLEN-LGMEMSZ){1'b0}}, req_addr[LGMEMSZ+1:2]};
  assign o_wb_data   = bus_data;
  assign o_wb_sel    = req_funct3;
  assign o_rsp_rdata = (state == RSP) ? rsp_data : '0;
`ifdef WB_LSU_MISALIGN_TRAP_EN
  assign o_rsp_err   = (state == RSP) && rsp_err;
`else
  assign o_rsp_err   = 1'b0;
`endif

  // Address bits above the RAM depth are intentionally dropped.
  assign unused_addr_bits = &{1'b0, req_addr[XLEN-1:LGMEMSZ+2]};

endmodule

// File: tb/tb_wb_lsu.sv
// tb_wb_lsu: self-checking bench for wb_lsu. A behavioural word RAM acts as
// the Wishbone slave; an arithmetic reference model predicts load results,
// RAM contents, bus-transfer counts, error flag and latency.
// Honours WB_LSU_MISALIGN_TRAP_EN when defined for the build.
module tb_wb_lsu;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic        rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;
  logic        wb_cyc, wb_stb, wb_we, wb_stall, wb_ack;
  logic [31:0] wb_addr, wb_dout, wb_din;
  logic [2:0]  wb_sel;

  always #5 clk = ~clk;

  wb_lsu dut (
    .i_clk(clk), .i_reset(rst),
    .i_req_valid(req_valid), .o_req_ready(req_ready), .i_req_we(req_we),
    .i_req_funct3(req_funct3), .i_req_addr(req_addr), .i_req_wdata(req_wdata),
    .o_rsp_valid(rsp_valid), .o_rsp_rdata(rsp_rdata), .o_rsp_err(rsp_err),
    .o_wb_cyc(wb_cyc), .o_wb_stb(wb_stb), .o_wb_we(wb_we), .o_wb_addr(wb_addr),
    .o_wb_data(wb_dout), .o_wb_sel(wb_sel), .i_wb_data(wb_din),
    .i_wb_stall(wb_stall), .i_wb_ack(wb_ack)
  );

  logic [31:0] ram     [0:511];
  logic [31:0] ref_mem [0:511];
  logic        ack_q;
  logic [31:0] rdat_q;
  int          reads = 0, writes = 0, cyc_no = 0;
  int          stall_start = 0, stall_len = 0;
  bit          rand_stall = 1'b0;
  int          checks = 0, errors = 0;

  // Observations from the most recent request
  logic [31:0] obs_rdata;
  logic        obs_err, obs_seen, ready_at_req, pulse_after, ready_after;
  int          obs_lat, unstable, bad_sel, bad_addr;

  always @(posedge clk) cyc_no <= cyc_no + 1;

  // Block RAM slave: registered ack and read data, word writes only
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      ack_q  <= 1'b0;
      rdat_q <= '0;
    end else begin
      ack_q <= 1'b0;
      if (wb_cyc && wb_stb && !wb_stall) begin
        ack_q <= 1'b1;
        if (wb_we) begin
          ram[wb_addr[8:0]] <= wb_dout;
          writes <= writes + 1;
        end else begin
          rdat_q <= ram[wb_addr[8:0]];
          reads <= reads + 1;
        end
      end
    end
  end
  assign wb_ack = ack_q;
  assign wb_din = rdat_q;

  // Stall: a directed window measured from the accepting edge, plus optional random stalls
  always @(negedge clk) begin
    wb_stall = ((cyc_no >= stall_start) && (cyc_no < stall_start + stall_len)) ||
               (rand_stall && ($urandom_range(0, 2) == 0));
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Issue one request, then watch the bus and wait (bounded) for the response
  task automatic applyStimulus(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                               input logic [31:0] wd, input int stall_cycles);
    logic [31:0] cap_addr, cap_data;
    logic        cap_we, in_burst;
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd;
    ready_at_req = req_ready;
    @(posedge clk);
    #1;
    stall_start = cyc_no;
    stall_len   = stall_cycles;
    req_valid = 1'b0; req_we = 1'b0; req_funct3 = '0; req_addr = '0; req_wdata = '0;
    obs_lat = 1; obs_seen = 1'b0; obs_rdata = '0; obs_err = 1'b0;
    unstable = 0; bad_sel = 0; bad_addr = 0; in_burst = 1'b0;
    cap_addr = '0; cap_data = '0; cap_we = 1'b0;
    while (!obs_seen && obs_lat < 300) begin
      @(negedge clk);
      if (wb_stb) begin
        if (!in_burst) begin
          cap_addr = wb_addr; cap_data = wb_dout; cap_we = wb_we;
        end else if (wb_addr !== cap_addr || wb_dout !== cap_data || wb_we !== cap_we) begin
          unstable++;
        end
        in_burst = 1'b1;
        if (wb_sel !== f3) bad_sel++;
        if (wb_addr >= 32'd512) bad_addr++;
      end else begin
        in_burst = 1'b0;
      end
      if (rsp_valid) begin
        obs_seen = 1'b1; obs_rdata = rsp_rdata; obs_err = rsp_err;
      end else begin
        obs_lat++;
      end
    end
    @(negedge clk);
    pulse_after = rsp_valid;
    ready_after = req_ready;
    stall_len = 0;
  endtask

  // Reference model: expected behaviour from address/size arithmetic
  task automatic modelOp(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wd, output logic [31:0] exp_rdata, output logic exp_err,
                         output int exp_lat, output int exp_reads, output int exp_writes,
                         output int widx, output logic do_write, output logic [31:0] new_word);
    int nbytes, off;
    bit uns, mis;
    logic [31:0] eff, word, mask, val;
    if (we) nbytes = (f3 == 3'd0) ? 1 : (f3 == 3'd1) ? 2 : 4;
    else    nbytes = (f3 == 3'd0 || f3 == 3'd4) ? 1 : (f3 == 3'd1 || f3 == 3'd5) ? 2 : 4;
    uns = !we && (f3 == 3'd4 || f3 == 3'd5);
    mis = (addr % nbytes) != 0;
    exp_rdata = '0; exp_err = 1'b0; exp_reads = 0; exp_writes = 0;
    do_write = 1'b0; new_word = '0; exp_lat = 3;
    widx = int'((addr / 4) % 512);
`ifdef WB_LSU_MISALIGN_TRAP_EN
    if (mis) begin
      exp_err = 1'b1;
      exp_lat = 1;
    end else
`endif
    begin
      eff  = addr - (addr % nbytes);
      off  = int'(eff % 4);
      widx = int'((eff / 4) % 512);
      word = ref_mem[widx];
      mask = (nbytes == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * nbytes)) - 32'd1);
      if (!we) begin
        val = (word >> (8 * off)) & mask;
        if (!uns && nbytes < 4 && val[8 * nbytes - 1]) val = val | ~mask;
        exp_rdata = val;
        exp_reads = 1;
        exp_lat   = 3;
      end else begin
        new_word   = (word & ~(mask << (8 * off))) | ((wd & mask) << (8 * off));
        do_write   = 1'b1;
        exp_writes = 1;
        exp_reads  = (nbytes < 4) ? 1 : 0;
        exp_lat    = (nbytes < 4) ? 5 : 3;
      end
    end
  endtask

  task automatic runOp(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wd, input int stall_cycles, input bit check_lat);
    logic [31:0] exp_rdata, new_word;
    logic        exp_err, do_write;
    int          exp_lat, exp_reads, exp_writes, widx, r0, w0;
    modelOp(we, f3, addr, wd, exp_rdata, exp_err, exp_lat, exp_reads, exp_writes,
            widx, do_write, new_word);
    r0 = reads; w0 = writes;
    applyStimulus(we, f3, addr, wd, stall_cycles);
    checkOutput("ready_before_req", ready_at_req, 1);
    checkOutput("rsp_seen", obs_seen, 1);
    checkOutput("rsp_rdata", obs_rdata, exp_rdata);
    checkOutput("rsp_err", obs_err, exp_err);
    if (check_lat) checkOutput("latency", obs_lat, exp_lat);
    checkOutput("bus_reads", reads - r0, exp_reads);
    checkOutput("bus_writes", writes - w0, exp_writes);
    if (do_write) ref_mem[widx] = new_word;
    checkOutput("ram_word", ram[widx], ref_mem[widx]);
    checkOutput("stb_stable", unstable, 0);
    checkOutput("wb_sel", bad_sel, 0);
    checkOutput("wb_addr_range", bad_addr, 0);
    checkOutput("rsp_one_cycle", pulse_after, 0);
    checkOutput("ready_after_rsp", ready_after, 1);
  endtask

  initial begin
    int seen;
    logic [31:0] v;
    for (int i = 0; i < 512; i++) begin
      v = $urandom;
      ram[i] = v;
      ref_mem[i] = v;
    end
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_funct3 = '0; req_addr = '0; req_wdata = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_ready", req_ready, 1);
    checkOutput("rst_rsp_valid", rsp_valid, 0);
    checkOutput("rst_cyc_stb_we", {wb_cyc, wb_stb, wb_we}, 0);
    checkOutput("rst_wb_addr", wb_addr, 0);
    checkOutput("rst_wb_data", wb_dout, 0);
    checkOutput("rst_rdata_err_sel", {rsp_rdata[28:0], rsp_err, wb_sel}, 0);
    rst = 1'b0;

    ram[4] = 32'hDEAD_BEEF;
    ref_mem[4] = 32'hDEAD_BEEF;
    $display("[TB] directed: aligned loads and sub-word extraction");
    runOp(1'b0, 3'd2, 32'h10, '0, 0, 1'b1);
    checkOutput("lw_0x10", obs_rdata, 32'hDEAD_BEEF);
    checkOutput("lw_0x10_lat", obs_lat, 3);
    runOp(1'b0, 3'd0, 32'h13, '0, 0, 1'b1);
    checkOutput("lb_0x13", obs_rdata, 32'hFFFF_FFDE);
    runOp(1'b0, 3'd4, 32'h13, '0, 0, 1'b1);
    checkOutput("lbu_0x13", obs_rdata, 32'h0000_00DE);
    runOp(1'b0, 3'd5, 32'h12, '0, 0, 1'b1);
    checkOutput("lhu_0x12", obs_rdata, 32'h0000_DEAD);

    $display("[TB] directed: SB read-modify-write");
    runOp(1'b1, 3'd0, 32'h11, 32'h55, 0, 1'b1);
    checkOutput("sb_ram4", ram[4], 32'hDEAD_55EF);
    checkOutput("sb_lat", obs_lat, 5);

    $display("[TB] directed: SW with three stall cycles");
    runOp(1'b1, 3'd2, 32'h20, 32'h1234_5678, 3, 1'b0);
    checkOutput("sw_stall_lat", obs_lat, 6);
    checkOutput("sw_stall_ram8", ram[8], 32'h1234_5678);

    $display("[TB] directed: reset during SH read wait");
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'd1; req_addr = 32'h10; req_wdata = 32'hAAAA;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("sh_rdwait_cyc", wb_cyc, 1);
    checkOutput("sh_rdwait_stb", wb_stb, 0);
    rst = 1'b1;
    #1;
    checkOutput("rst_mid_cyc", wb_cyc, 0);
    checkOutput("rst_mid_stb", wb_stb, 0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    repeat (6) begin
      @(negedge clk);
      if (rsp_valid) seen++;
    end
    checkOutput("rst_mid_no_rsp", seen, 0);
    checkOutput("rst_mid_ready", req_ready, 1);
    checkOutput("rst_mid_ram4", ram[4], 32'hDEAD_55EF);

    $display("[TB] directed: misaligned LW");
    runOp(1'b0, 3'd2, 32'h12, '0, 0, 1'b1);
`ifdef WB_LSU_MISALIGN_TRAP_EN
    checkOutput("lw_0x12_err", obs_err, 1);
    checkOutput("lw_0x12_lat", obs_lat, 1);
`else
    checkOutput("lw_0x12_data", obs_rdata, 32'hDEAD_55EF);
`endif

    $display("[TB] randomized requests");
    for (int i = 0; i < 80; i++) begin
      rand_stall = (i >= 40);
      runOp(1'(($urandom & 1)), 3'($urandom_range(0, 7)), $urandom, $urandom, 0, !rand_stall);
    end
    rand_stall = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
